multicycle_core: RTL and testbench

MULTICYCLE_CORE -- requirements
Module: multicycle_core

---
 rtl/multicycle_core.sv | 231 +++++++++++++++++++++++
 tb/tb_multicycle_core.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_core.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_core
// Description : Multi-cycle 32-bit RISC core (FETCH/DECODE/EXEC/MEM/WB/HALT)
//               with one shared request/ack memory port.
//               Optional multiplier (R-type funct 5): MULTICYCLE_CORE_MUL_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_core #(
    parameter int              ADDR_W   = 16,
    parameter int              NREGS    = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic              halted,
    output logic              retire,
    output logic [ADDR_W-1:0] pc_out
);

    localparam int RIDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;

    localparam logic [7:0] c_OP_RTYPE = 8'h00;
    localparam logic [7:0] c_OP_ADDI  = 8'h08;
    localparam logic [7:0] c_OP_LW    = 8'h23;
    localparam logic [7:0] c_OP_SW    = 8'h2B;
    localparam logic [7:0] c_OP_BEQ   = 8'h04;
    localparam logic [7:0] c_OP_BNE   = 8'h05;
    localparam logic [7:0] c_OP_J     = 8'h02;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_pc;
    logic [31:0]         r_ir;
    logic [31:0]         r_a;
    logic [31:0]         r_b;
    logic [31:0]         r_res;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_regs [NREGS];

    logic [7:0]          w_opcode;
    logic [3:0]          w_funct;
    logic [RIDX_W-1:0]   w_rs;
    logic [RIDX_W-1:0]   w_rt;
    logic [RIDX_W-1:0]   w_rd;
    logic [RIDX_W-1:0]   w_dest;
    logic [31:0]         w_imm32;
    logic [31:0]         w_alu;
    logic                w_funct_ok;
    logic                w_legal;
    logic                w_taken;
    logic                w_retire;

    assign w_opcode = r_ir[31:24];
    assign w_funct  = r_ir[3:0];
    assign w_rs     = r_ir[20 +: RIDX_W];
    assign w_rt     = r_ir[16 +: RIDX_W];
    assign w_rd     = r_ir[12 +: RIDX_W];
    assign w_imm32  = {{16{r_ir[15]}}, r_ir[15:0]};
    assign w_dest   = (w_opcode == c_OP_RTYPE) ? w_rd : w_rt;
    assign w_taken  = (w_opcode == c_OP_BEQ) ? (r_a == r_b) : (r_a != r_b);

    // Legality is decided from IR alone so DECODE can divert straight to HALT.
    always_comb begin
        w_funct_ok = 1'b0;
        case (w_funct)
            4'd0, 4'd1, 4'd2, 4'd3, 4'd4: w_funct_ok = 1'b1;
`ifdef MULTICYCLE_CORE_MUL_EN
            4'd5:                         w_funct_ok = 1'b1;
`endif
            default:                      w_funct_ok = 1'b0;
        endcase
        w_legal = 1'b0;
        case (w_opcode)
            c_OP_RTYPE: w_legal = w_funct_ok;
            c_OP_ADDI, c_OP_LW, c_OP_SW,
            c_OP_BEQ, c_OP_BNE, c_OP_J: w_legal = 1'b1;
            default:    w_legal = 1'b0;
        endcase
    end

    always_comb begin
        w_alu = r_a + w_imm32;
        if (w_opcode == c_OP_RTYPE) begin
            case (w_funct)
                4'd0:    w_alu = r_a + r_b;
                4'd1:    w_alu = r_a - r_b;
                4'd2:    w_alu = r_a & r_b;
                4'd3:    w_alu = r_a | r_b;
                4'd4:    w_alu = {31'd0, ($signed(r_a) < $signed(r_b))};
`ifdef MULTICYCLE_CORE_MUL_EN
                4'd5:    w_alu = r_a * r_b;
`endif
                default: w_alu = r_a + r_b;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = r_pc;
        mem_wdata = '0;
        w_retire  = 1'b0;
        case (r_state)
            FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) w_next = DECODE;
            end
            DECODE: begin
                w_next = w_legal ? EXEC : HALT;
            end
            EXEC: begin
                case (w_opcode)
                    c_OP_RTYPE, c_OP_ADDI: w_next = WB;
                    c_OP_LW, c_OP_SW:      w_next = MEM;
                    c_OP_BEQ, c_OP_BNE, c_OP_J: begin
                        w_next   = FETCH;
                        w_retire = 1'b1;
                    end
                    default:               w_next = HALT;
                endcase
            end
            MEM: begin
                mem_req  = 1'b1;
                mem_addr = r_addr;
                if (w_opcode == c_OP_SW) begin
                    mem_we    = 1'b1;
                    mem_wdata = r_b;
                end
                if (mem_ack) begin
                    if (w_opcode == c_OP_SW) begin
                        w_next   = FETCH;
                        w_retire = 1'b1;
                    end else begin
                        w_next = WB;
                    end
                end
            end
            WB: begin
                w_next   = FETCH;
                w_retire = 1'b1;
            end
            HALT:    w_next = HALT;
            default: w_next = HALT;
        endcase
        // A transfer in flight when reset arrives is dropped on the port immediately.
        if (rst) begin
            mem_req  = 1'b0;
            w_retire = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc   <= RESET_PC;
            r_ir   <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_res  <= '0;
            r_addr <= '0;
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            case (r_state)
                FETCH: begin
                    if (mem_ack) begin
                        r_ir <= mem_rdata;
                        r_pc <= r_pc + ADDR_W'(4);
                    end
                end
                DECODE: begin
                    r_a <= (w_rs == '0) ? 32'd0 : r_regs[w_rs];
                    r_b <= (w_rt == '0) ? 32'd0 : r_regs[w_rt];
                end
                EXEC: begin
                    r_res  <= w_alu;
                    r_addr <= w_alu[ADDR_W-1:0];
                    // Branch offset is relative to the already-incremented PC, in bytes.
                    if (((w_opcode == c_OP_BEQ) || (w_opcode == c_OP_BNE)) && w_taken) begin
                        r_pc <= r_pc + ADDR_W'(w_imm32);
                    end else if (w_opcode == c_OP_J) begin
                        r_pc <= ADDR_W'({8'd0, r_ir[23:0]});
                    end
                end
                MEM: begin
                    if (mem_ack && (w_opcode != c_OP_SW)) begin
                        r_res <= mem_rdata;
                    end
                end
                WB: begin
                    if (w_dest != '0) begin
                        r_regs[w_dest] <= r_res;
                    end
                end
                default: ;
            endcase
        end
    end

    assign halted = (r_state == HALT);
    assign retire = w_retire;
    assign pc_out = r_pc;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_core
// Description : Directed self-checking bench for multicycle_core with a
//               behavioural memory responder (programmable ack delay).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_core;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        halted;
    logic        retire;
    logic [15:0] pc_out;

    always #5 clk = ~clk;

    multicycle_core #(
        .ADDR_W   (16),
        .NREGS    (16),
        .RESET_PC (16'h0000)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .halted    (halted),
        .retire    (retire),
        .pc_out    (pc_out)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Word-addressed memory, 512 bytes
    logic [31:0] mem [0:127];
    int          ack_delay   = 0;
    bit          hold_writes = 1'b0;
    bit          stray_ack   = 1'b0;

    // Responder: decides ack shortly after each rising edge, checks port stability while waiting.
    initial begin
        int          wcnt;
        bit          waiting;
        logic [15:0] p_addr;
        logic        p_we;
        logic [31:0] p_wdata;
        wcnt = 0; waiting = 1'b0; p_addr = '0; p_we = 1'b0; p_wdata = '0;
        mem_ack = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            if (stray_ack) begin
                mem_ack = 1'b1; wcnt = 0; waiting = 1'b0;
            end else if (mem_req) begin
                if (waiting) begin
                    check_val("hold_addr", 32'(mem_addr), 32'(p_addr));
                    check_val("hold_we", 32'(mem_we), 32'(p_we));
                    check_val("hold_wdata", mem_wdata, p_wdata);
                end
                if (wcnt >= ack_delay && !(mem_we && hold_writes)) begin
                    mem_ack = 1'b1;
                    if (mem_we) mem[mem_addr[8:2]] = mem_wdata;
                    else        mem_rdata = mem[mem_addr[8:2]];
                    wcnt = 0; waiting = 1'b0;
                end else begin
                    mem_ack = 1'b0; wcnt++; waiting = 1'b1;
                    p_addr = mem_addr; p_we = mem_we; p_wdata = mem_wdata;
                end
            end else begin
                mem_ack = 1'b0; wcnt = 0; waiting = 1'b0;
            end
        end
    end

    int          cyc;
    int          halt_cyc;
    int          retire_cyc[$];
    logic [15:0] retire_pc[$];
    logic [15:0] next_fetch[$];

    task automatic start_rst(input bit with_stray);
        @(posedge clk);
        #1 rst = 1'b1;
        stray_ack = with_stray;
        @(negedge clk);
        check_val("rst_no_req", 32'(mem_req), 32'd0);
    endtask

    task automatic release_rst();
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        stray_ack = 1'b0;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 128; i++) mem[i] = 32'hFF00_0000;
    endtask

    // Cycle 1 is the first cycle with rst low; retire/halt are sampled mid-cycle.
    task automatic run_to_halt(input int budget);
        bit pend;
        pend = 1'b0; cyc = 0; halt_cyc = -1;
        retire_cyc.delete(); retire_pc.delete(); next_fetch.delete();
        while (cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (pend) begin next_fetch.push_back(mem_addr); pend = 1'b0; end
            if (retire) begin
                retire_cyc.push_back(cyc);
                retire_pc.push_back(pc_out);
                pend = 1'b1;
            end
            if (halted) begin halt_cyc = cyc; break; end
        end
    endtask

    int expA[19] = '{4, 8, 12, 16, 20, 24, 28, 32, 35, 38, 42, 46, 50, 54, 58, 62, 66, 70, 73};

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- Test A: ALU ops, branches, jump, zero-wait ----------------
        start_rst(1'b0);
        ack_delay = 0; hold_writes = 1'b0;
        clear_mem();
        mem[16'h00>>2] = 32'h0801_0005; // addi r1,r0,5
        mem[16'h04>>2] = 32'h0802_0007; // addi r2,r0,7
        mem[16'h08>>2] = 32'h0012_3000; // add  r3,r1,r2
        mem[16'h0C>>2] = 32'h2B03_0100; // sw   r3,0x100
        mem[16'h10>>2] = 32'h0012_4001; // sub  r4,r1,r2
        mem[16'h14>>2] = 32'h2B04_0104;
        mem[16'h18>>2] = 32'h0041_5004; // slt  r5,r4,r1
        mem[16'h1C>>2] = 32'h2B05_0108;
        mem[16'h20>>2] = 32'h0411_0010; // beq  r1,r1,+0x10 -> 0x34
        mem[16'h34>>2] = 32'h0511_0010; // bne  r1,r1 (not taken)
        mem[16'h38>>2] = 32'h0012_6002; // and  r6
        mem[16'h3C>>2] = 32'h2B06_010C;
        mem[16'h40>>2] = 32'h0012_7003; // or   r7
        mem[16'h44>>2] = 32'h2B07_0110;
        mem[16'h48>>2] = 32'h0808_FFFF; // addi r8,r0,-1
        mem[16'h4C>>2] = 32'h2B08_0114;
        mem[16'h50>>2] = 32'h0800_0009; // addi r0,r0,9 (discarded)
        mem[16'h54>>2] = 32'h2B00_0118;
        mem[16'h58>>2] = 32'h0200_0080; // j 0x80 (illegal word there)
        release_rst();
        run_to_halt(300);
        check_val("A_retire_count", 32'(retire_cyc.size()), 32'd19);
        if (retire_cyc.size() == 19) begin
            for (int i = 0; i < 19; i++)
                check_val($sformatf("A_retire_cyc%0d", i), 32'(retire_cyc[i]), 32'(expA[i]));
            check_val("A_add_pc", 32'(retire_pc[2]), 32'h0C);
            check_val("A_beq_next_fetch", 32'(next_fetch[8]), 32'h34);
            check_val("A_bne_next_fetch", 32'(next_fetch[9]), 32'h38);
            check_val("A_j_next_fetch", 32'(next_fetch[18]), 32'h80);
        end
        check_val("A_halt_cyc", 32'(halt_cyc), 32'd76);
        check_val("A_add", mem[16'h100>>2], 32'd12);
        check_val("A_sub", mem[16'h104>>2], 32'hFFFF_FFFE);
        check_val("A_slt", mem[16'h108>>2], 32'd1);
        check_val("A_and", mem[16'h10C>>2], 32'd5);
        check_val("A_or",  mem[16'h110>>2], 32'd7);
        check_val("A_addi_neg", mem[16'h114>>2], 32'hFFFF_FFFF);
        check_val("A_r0_zero", mem[16'h118>>2], 32'd0);
        check_val("A_halt_pc", 32'(pc_out), 32'h84);

        // ---------------- Test B: lw/sw with 3 wait cycles per transfer ----------------
        start_rst(1'b0);
        ack_delay = 3;
        clear_mem();
        mem[0] = 32'h2304_0008;          // lw r4,8(r0)
        mem[1] = 32'h2B04_0120;          // sw r4,0x120(r0)
        mem[2] = 32'hDEAD_BEEF;          // data, then fetched as illegal
        release_rst();
        run_to_halt(200);
        check_val("B_retire_count", 32'(retire_cyc.size()), 32'd2);
        if (retire_cyc.size() == 2) begin
            check_val("B_lw_cycles", 32'(retire_cyc[0]), 32'd11);
            check_val("B_sw_cycles", 32'(retire_cyc[1]), 32'd21);
        end
        check_val("B_halt_cyc", 32'(halt_cyc), 32'd27);
        check_val("B_lw_data", mem[16'h120>>2], 32'hDEAD_BEEF);

        // ---------------- Test C: reset abandons a pending store ----------------
        start_rst(1'b0);
        ack_delay = 0; hold_writes = 1'b1;
        clear_mem();
        mem[0] = 32'h2B00_0130;          // sw r0,0x130(r0)
        mem[16'h130>>2] = 32'h1234_5678;
        release_rst();
        repeat (6) @(negedge clk);
        check_val("C_sw_req", 32'(mem_req), 32'd1);
        check_val("C_sw_we", 32'(mem_we), 32'd1);
        check_val("C_sw_addr", 32'(mem_addr), 32'h130);
        start_rst(1'b1);                 // stray acks driven throughout reset
        release_rst();
        @(negedge clk);
        check_val("C_fetch_req", 32'(mem_req), 32'd1);
        check_val("C_fetch_we", 32'(mem_we), 32'd0);
        check_val("C_fetch_addr", 32'(mem_addr), 32'h0);
        check_val("C_store_dropped", mem[16'h130>>2], 32'h1234_5678);
        check_val("C_no_halt", 32'(halted), 32'd0);

        // ---------------- Test D: illegal opcode, absorbing HALT, reset exit ----------------
        start_rst(1'b0);
        hold_writes = 1'b0;
        clear_mem();
        release_rst();
        run_to_halt(50);
        check_val("D_halt_cyc", 32'(halt_cyc), 32'd3);
        check_val("D_no_retire", 32'(retire_cyc.size()), 32'd0);
        stray_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_val($sformatf("D_halt_req%0d", i), 32'(mem_req), 32'd0);
            check_val($sformatf("D_halt_flag%0d", i), 32'(halted), 32'd1);
            check_val($sformatf("D_halt_pc%0d", i), 32'(pc_out), 32'h4);
            check_val($sformatf("D_halt_retire%0d", i), 32'(retire), 32'd0);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        stray_ack = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_val("D_exit_halted", 32'(halted), 32'd0);
        check_val("D_exit_req", 32'(mem_req), 32'd1);
        check_val("D_exit_addr", 32'(mem_addr), 32'h0);

        // ---------------- Test E: funct 5 (mul or illegal) ----------------
        start_rst(1'b0);
        clear_mem();
        mem[0] = 32'h2301_0040;          // lw r1,0x40
        mem[1] = 32'h2302_0044;          // lw r2,0x44
        mem[2] = 32'h0012_3005;          // funct 5 r3,r1,r2
        mem[3] = 32'h2B03_0048;          // sw r3,0x48
        mem[16'h40>>2] = 32'h0001_0000;
        mem[16'h44>>2] = 32'h0001_0001;
        mem[16'h48>>2] = 32'hAAAA_AAAA;
        release_rst();
        run_to_halt(200);
`ifdef MULTICYCLE_CORE_MUL_EN
        check_val("E_retire_count", 32'(retire_cyc.size()), 32'd4);
        if (retire_cyc.size() == 4) check_val("E_mul_cycles", 32'(retire_cyc[2]), 32'd14);
        check_val("E_mul_result", mem[16'h48>>2], 32'h0001_0000);
        check_val("E_halt_cyc", 32'(halt_cyc), 32'd21);
        check_val("E_halt_pc", 32'(pc_out), 32'h14);
`else
        check_val("E_retire_count", 32'(retire_cyc.size()), 32'd2);
        check_val("E_halt_cyc", 32'(halt_cyc), 32'd13);
        check_val("E_halt_pc", 32'(pc_out), 32'h0C);
        check_val("E_no_store", mem[16'h48>>2], 32'hAAAA_AAAA);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
